// File: rtl/ex_operand_stage_if.sv
// Purpose : bundle of decode, forwarding, execute-handshake and ALU-operand signals
//           for the ID/EX operand stage. master = surrounding pipeline, slave = stage.
// Ports   : decode (in_*), flush, ex_ready, EX/MEM and MEM/WB snoop, ALU outputs, stall_cnt.
interface ex_operand_stage_if #(
    parameter int XLEN        = 64,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    // decode side
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_alu_op;
    logic [REG_ADDR_W-1:0]  in_rs1_addr;
    logic [REG_ADDR_W-1:0]  in_rs2_addr;
    logic [XLEN-1:0]        in_rs1_data;
    logic [XLEN-1:0]        in_rs2_data;
    logic [XLEN-1:0]        in_imm;
    logic [XLEN-1:0]        in_pc;
    logic                   in_a_sel;
    logic                   in_b_sel;
    logic                   in_is_store;
    logic [REG_ADDR_W-1:0]  in_rd_addr;
    logic                   in_rd_we;
    logic                   flush;
    // execute side
    logic                   ex_ready;
    logic                   out_valid;
    logic [3:0]             alu_op;
    logic [XLEN-1:0]        input_alu_A;
    logic [XLEN-1:0]        input_alu_B;
    logic [XLEN-1:0]        out_store_data;
    logic [REG_ADDR_W-1:0]  out_rd_addr;
    logic                   out_rd_we;
    logic [STALL_CNT_W-1:0] stall_cnt;
    // later pipeline stages
    logic [REG_ADDR_W-1:0]  exmem_rd_addr;
    logic                   exmem_rd_we;
    logic                   exmem_is_load;
    logic [XLEN-1:0]        exmem_result;
    logic [REG_ADDR_W-1:0]  memwb_rd_addr;
    logic                   memwb_rd_we;
    logic [XLEN-1:0]        memwb_result;

    modport master (
        output in_valid, in_alu_op, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_pc, in_a_sel, in_b_sel, in_is_store, in_rd_addr, in_rd_we,
               flush, ex_ready, exmem_rd_addr, exmem_rd_we, exmem_is_load, exmem_result,
               memwb_rd_addr, memwb_rd_we, memwb_result,
        input  in_ready, out_valid, alu_op, input_alu_A, input_alu_B, out_store_data,
               out_rd_addr, out_rd_we, stall_cnt
    );

    modport slave (
        input  in_valid, in_alu_op, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_pc, in_a_sel, in_b_sel, in_is_store, in_rd_addr, in_rd_we,
               flush, ex_ready, exmem_rd_addr, exmem_rd_we, exmem_is_load, exmem_result,
               memwb_rd_addr, memwb_rd_we, memwb_result,
        output in_ready, out_valid, alu_op, input_alu_A, input_alu_B, out_store_data,
               out_rd_addr, out_rd_we, stall_cnt
    );
endinterface

// File: rtl/ex_operand_stage.sv
// Purpose : ID/EX register + operand select with EX/MEM, MEM/WB forwarding and load-use stall.
// Latency : 1 cycle accept -> out_valid when no hazard; full throughput with ex_ready=1.
// Backpr. : in_ready = !valid | (out_valid & ex_ready); held instruction is stable while stalled.
// Ports   : clk, rst_n (async, active low); bus (slave modport) carries decode inputs,
//           flush, ex_ready, EX/MEM + MEM/WB forwarding sources and ALU operand outputs.
module ex_operand_stage #(
    parameter int XLEN        = 64,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_operand_stage_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HAZARD = 2'd2
    } stage_state_e;

    // held instruction; r_valid is the only real state bit, the enum is its decoded view
    logic                   r_valid;
    logic [3:0]             r_alu_op;
    logic [REG_ADDR_W-1:0]  r_rs1_addr;
    logic [REG_ADDR_W-1:0]  r_rs2_addr;
    logic [XLEN-1:0]        r_rs1_data;
    logic [XLEN-1:0]        r_rs2_data;
    logic [XLEN-1:0]        r_imm;
    logic [XLEN-1:0]        r_pc;
    logic                   r_a_sel;
    logic                   r_b_sel;
    logic                   r_is_store;
    logic [REG_ADDR_W-1:0]  r_rd_addr;
    logic                   r_rd_we;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    stage_state_e           w_state;
    logic                   w_uses_rs1;
    logic                   w_uses_rs2;
    logic                   w_ex_load;
    logic                   w_ex_fwd;
    logic                   w_wb_fwd;
    logic                   w_hazard;
    logic                   w_out_valid;
    logic                   w_fire;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_snoop_rs1;
    logic                   w_snoop_rs2;
    logic                   w_stall_sat;
    logic [XLEN-1:0]        w_fwd_rs1;
    logic [XLEN-1:0]        w_fwd_rs2;

    // store data needs rs2 even when B takes the immediate
    assign w_uses_rs1 = ~r_a_sel;
    assign w_uses_rs2 = ~r_b_sel | r_is_store;

    // x0 writes are architecturally void, so they neither stall nor forward
    assign w_ex_load = bus.exmem_rd_we & bus.exmem_is_load & (bus.exmem_rd_addr != '0);
    assign w_ex_fwd  = bus.exmem_rd_we & ~bus.exmem_is_load & (bus.exmem_rd_addr != '0);
    assign w_wb_fwd  = bus.memwb_rd_we & (bus.memwb_rd_addr != '0);

    assign w_hazard = r_valid & w_ex_load &
                      ((w_uses_rs1 & (bus.exmem_rd_addr == r_rs1_addr)) |
                       (w_uses_rs2 & (bus.exmem_rd_addr == r_rs2_addr)));

    always_comb begin
        w_state = ST_EMPTY;
        if (r_valid) begin
            w_state = w_hazard ? ST_HAZARD : ST_ISSUE;
        end
    end

    assign w_out_valid = (w_state == ST_ISSUE);
    assign w_fire      = w_out_valid & bus.ex_ready;
    assign w_in_ready  = ~r_valid | w_fire;
    assign w_accept    = bus.in_valid & w_in_ready;

    // newest producer wins: EX/MEM over MEM/WB over the register-file copy
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (r_rs1_addr != '0) begin
            if (w_ex_fwd && (bus.exmem_rd_addr == r_rs1_addr)) begin
                w_fwd_rs1 = bus.exmem_result;
            end else if (w_wb_fwd && (bus.memwb_rd_addr == r_rs1_addr)) begin
                w_fwd_rs1 = bus.memwb_result;
            end
        end
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (r_rs2_addr != '0) begin
            if (w_ex_fwd && (bus.exmem_rd_addr == r_rs2_addr)) begin
                w_fwd_rs2 = bus.exmem_result;
            end else if (w_wb_fwd && (bus.memwb_rd_addr == r_rs2_addr)) begin
                w_fwd_rs2 = bus.memwb_result;
            end
        end
    end

    // a value retiring from MEM/WB while we wait would otherwise be lost next cycle
    assign w_snoop_rs1 = w_wb_fwd & (bus.memwb_rd_addr == r_rs1_addr);
    assign w_snoop_rs2 = w_wb_fwd & (bus.memwb_rd_addr == r_rs2_addr);
    assign w_stall_sat = (r_stall_cnt == {STALL_CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_alu_op   <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_a_sel    <= 1'b0;
            r_b_sel    <= 1'b0;
            r_is_store <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_alu_op   <= bus.in_alu_op;
            r_rs1_addr <= bus.in_rs1_addr;
            r_rs2_addr <= bus.in_rs2_addr;
            r_rs1_data <= bus.in_rs1_data;
            r_rs2_data <= bus.in_rs2_data;
            r_imm      <= bus.in_imm;
            r_pc       <= bus.in_pc;
            r_a_sel    <= bus.in_a_sel;
            r_b_sel    <= bus.in_b_sel;
            r_is_store <= bus.in_is_store;
            r_rd_addr  <= bus.in_rd_addr;
            r_rd_we    <= bus.in_rd_we;
        end else begin
            if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (r_valid && w_snoop_rs1) begin
                r_rs1_data <= bus.memwb_result;
            end
            if (r_valid && w_snoop_rs2) begin
                r_rs2_data <= bus.memwb_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !w_stall_sat) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.alu_op         = r_alu_op;
    assign bus.input_alu_A    = r_a_sel ? r_pc  : w_fwd_rs1;
    assign bus.input_alu_B    = r_b_sel ? r_imm : w_fwd_rs2;
    assign bus.out_store_data = w_fwd_rs2;
    assign bus.out_rd_addr    = r_rd_addr;
    assign bus.out_rd_we      = r_rd_we & w_out_valid;
    assign bus.stall_cnt      = r_stall_cnt;
endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
    localparam int XLEN = 64;
    localparam int RAW  = 5;
    localparam int SCW  = 4;   // narrow counter so saturation is reachable quickly

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_operand_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .STALL_CNT_W(SCW)) bus ();
    ex_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .STALL_CNT_W(SCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        a_sel;
        logic        b_sel;
        logic        is_store;
        logic [4:0]  rd_addr;
        logic        rd_we;
    } dec_t;

    typedef struct packed {
        logic        flush;
        logic        ex_ready;
        logic [4:0]  ex_rd;
        logic        ex_we;
        logic        ex_ld;
        logic [63:0] ex_res;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [63:0] wb_res;
    } side_t;

    typedef struct {
        logic           in_valid;
        dec_t           d;
        side_t          s;
        logic           e_vld;
        logic           e_rdy;
        logic [63:0]    e_a;
        logic [63:0]    e_b;
        logic [63:0]    e_sd;
        logic [SCW-1:0] e_stall;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic dec_t mk(input logic [3:0] op, input logic [4:0] r1, input logic [63:0] d1,
                                input logic [4:0] r2, input logic [63:0] d2, input logic [63:0] imm,
                                input logic [63:0] pc, input logic asel, input logic bsel,
                                input logic st, input logic [4:0] rd, input logic we);
        dec_t d;
        d.alu_op = op;   d.rs1_addr = r1; d.rs1_data = d1; d.rs2_addr = r2; d.rs2_data = d2;
        d.imm = imm;     d.pc = pc;       d.a_sel = asel;  d.b_sel = bsel;   d.is_store = st;
        d.rd_addr = rd;  d.rd_we = we;
        return d;
    endfunction

    function automatic side_t sd(input logic rdy, input logic [4:0] exrd, input logic exwe,
                                 input logic exld, input logic [63:0] exres, input logic [4:0] wbrd,
                                 input logic wbwe, input logic [63:0] wbres);
        side_t s;
        s.flush = 1'b0; s.ex_ready = rdy;
        s.ex_rd = exrd; s.ex_we = exwe; s.ex_ld = exld; s.ex_res = exres;
        s.wb_rd = wbrd; s.wb_we = wbwe; s.wb_res = wbres;
        return s;
    endfunction

    function automatic vec_t mv(input logic v, input dec_t d, input side_t s, input logic ev,
                                input logic er, input logic [63:0] ea, input logic [63:0] eb,
                                input logic [63:0] esd, input logic [SCW-1:0] es);
        vec_t t;
        t.in_valid = v; t.d = d; t.s = s; t.e_vld = ev; t.e_rdy = er;
        t.e_a = ea; t.e_b = eb; t.e_sd = esd; t.e_stall = es;
        return t;
    endfunction

    task automatic drive(input logic v, input dec_t d, input side_t s);
        bus.in_valid      = v;
        bus.in_alu_op     = d.alu_op;
        bus.in_rs1_addr   = d.rs1_addr;
        bus.in_rs2_addr   = d.rs2_addr;
        bus.in_rs1_data   = d.rs1_data;
        bus.in_rs2_data   = d.rs2_data;
        bus.in_imm        = d.imm;
        bus.in_pc         = d.pc;
        bus.in_a_sel      = d.a_sel;
        bus.in_b_sel      = d.b_sel;
        bus.in_is_store   = d.is_store;
        bus.in_rd_addr    = d.rd_addr;
        bus.in_rd_we      = d.rd_we;
        bus.flush         = s.flush;
        bus.ex_ready      = s.ex_ready;
        bus.exmem_rd_addr = s.ex_rd;
        bus.exmem_rd_we   = s.ex_we;
        bus.exmem_is_load = s.ex_ld;
        bus.exmem_result  = s.ex_res;
        bus.memwb_rd_addr = s.wb_rd;
        bus.memwb_rd_we   = s.wb_we;
        bus.memwb_result  = s.wb_res;
    endtask

    // apply inputs mid-cycle, then let combinational outputs settle before sampling
    task automatic step(input logic v, input dec_t d, input side_t s);
        @(negedge clk);
        drive(v, d, s);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic           m_valid;
    dec_t           m_q;
    logic [SCW-1:0] m_stall;

    // value a reader of register a sees: newest non-load producer in flight, else its own copy
    function automatic logic [63:0] m_fwd(input logic [4:0] a, input logic [63:0] held, input side_t s);
        logic [4:0]  pa [2];
        logic        pv [2];
        logic [63:0] pd [2];
        pa[0] = s.ex_rd; pv[0] = s.ex_we && !s.ex_ld; pd[0] = s.ex_res;
        pa[1] = s.wb_rd; pv[1] = s.wb_we;             pd[1] = s.wb_res;
        if (a == 5'd0) return held;
        for (int k = 0; k < 2; k++) begin
            if (pv[k] && pa[k] == a) return pd[k];
        end
        return held;
    endfunction

    function automatic logic m_hazard(input side_t s);
        logic reads_rs1, reads_rs2;
        reads_rs1 = !m_q.a_sel;
        reads_rs2 = !m_q.b_sel || m_q.is_store;
        if (!m_valid || !s.ex_we || !s.ex_ld || s.ex_rd == 5'd0) return 1'b0;
        return (reads_rs1 && m_q.rs1_addr == s.ex_rd) || (reads_rs2 && m_q.rs2_addr == s.ex_rd);
    endfunction

    function automatic dec_t rnd_dec();
        dec_t d;
        d.alu_op   = 4'($urandom_range(0, 15));
        d.rs1_addr = 5'($urandom_range(0, 3));
        d.rs2_addr = 5'($urandom_range(0, 3));
        d.rs1_data = {$urandom(), $urandom()};
        d.rs2_data = {$urandom(), $urandom()};
        d.imm      = {$urandom(), $urandom()};
        d.pc       = {$urandom(), $urandom()};
        d.a_sel    = 1'($urandom_range(0, 1));
        d.b_sel    = 1'($urandom_range(0, 1));
        d.is_store = 1'($urandom_range(0, 1));
        d.rd_addr  = 5'($urandom_range(0, 31));
        d.rd_we    = 1'($urandom_range(0, 1));
        return d;
    endfunction

    function automatic side_t rnd_side();
        side_t s;
        s.flush    = ($urandom_range(0, 15) == 0);
        s.ex_ready = ($urandom_range(0, 3) != 0);
        s.ex_rd    = 5'($urandom_range(0, 3));
        s.ex_we    = 1'($urandom_range(0, 1));
        s.ex_ld    = ($urandom_range(0, 2) == 0);
        s.ex_res   = {$urandom(), $urandom()};
        s.wb_rd    = 5'($urandom_range(0, 3));
        s.wb_we    = 1'($urandom_range(0, 1));
        s.wb_res   = {$urandom(), $urandom()};
        return s;
    endfunction

    vec_t  tv [14];
    dec_t  i1, i2, i3, i4, i5, i6, i7, dz;
    side_t idle, s_stall, s_flush, s_ld5;

    initial begin
        dz   = '0;
        idle = sd(1'b1, 5'd0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0);
        i1 = mk(4'h0, 5'd5, 64'd10,  5'd6, 64'd20,  64'h0,   64'h1000, 1'b0, 1'b0, 1'b0, 5'd7,  1'b1);
        i2 = mk(4'h1, 5'd5, 64'h1,   5'd0, 64'h0,   64'h100, 64'h1004, 1'b0, 1'b1, 1'b0, 5'd8,  1'b1);
        i3 = mk(4'h2, 5'd0, 64'h0,   5'd0, 64'h0,   64'h5,   64'h1008, 1'b0, 1'b1, 1'b0, 5'd9,  1'b1);
        i4 = mk(4'h3, 5'd5, 64'h33,  5'd6, 64'h44,  64'h0,   64'h100c, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1);
        i5 = mk(4'h4, 5'd1, 64'h3,   5'd2, 64'h4,   64'h0,   64'h1010, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1);
        i6 = mk(4'h5, 5'd3, 64'h10,  5'd4, 64'h20,  64'h0,   64'h1014, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
        i7 = mk(4'h6, 5'd1, 64'h1,   5'd9, 64'h55,  64'h8,   64'h1018, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0);

        // one row per cycle: inputs, then outputs expected before that cycle's edge
        tv[0]  = mv(1, i1, idle, 0, 1, 0, 0, 0, 0);
        tv[1]  = mv(1, i2, idle, 1, 1, 64'd10, 64'd20, 64'd20, 0);
        tv[2]  = mv(1, i3, sd(1, 5'd5, 1, 0, 64'h77, 5'd5, 1, 64'h11), 1, 1, 64'h77, 64'h100, 64'h0, 0);
        tv[3]  = mv(1, i4, sd(1, 5'd0, 1, 0, 64'hFF, 5'd0, 1, 64'hEE), 1, 1, 64'h0, 64'h5, 64'h0, 0);
        tv[4]  = mv(1, i5, sd(1, 5'd5, 1, 1, 64'hDEAD, 5'd0, 0, 64'h0), 0, 0, 0, 0, 0, 0);
        tv[5]  = mv(1, i5, sd(1, 5'd0, 0, 0, 64'h0, 5'd5, 1, 64'hAB), 1, 1, 64'hAB, 64'h44, 64'h44, 1);
        tv[6]  = mv(0, dz, idle, 1, 1, 64'h3, 64'h4, 64'h4, 1);
        tv[7]  = mv(1, i6, idle, 0, 1, 0, 0, 0, 1);
        tv[8]  = mv(0, dz, sd(0, 5'd0, 0, 0, 64'h0, 5'd3, 1, 64'h99), 1, 0, 64'h99, 64'h20, 64'h20, 1);
        tv[9]  = mv(0, dz, idle, 1, 1, 64'h99, 64'h20, 64'h20, 1);
        tv[10] = mv(1, i7, idle, 0, 1, 0, 0, 0, 1);
        tv[11] = mv(0, dz, sd(1, 5'd9, 1, 1, 64'h0, 5'd0, 0, 64'h0), 0, 0, 0, 0, 0, 1);
        tv[12] = mv(0, dz, sd(1, 5'd9, 1, 0, 64'h66, 5'd0, 0, 64'h0), 1, 1, 64'h1, 64'h8, 64'h66, 2);
        tv[13] = mv(0, dz, idle, 0, 1, 0, 0, 0, 2);

        // reset state
        drive(1'b0, dz, idle);
        repeat (2) @(negedge clk);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst alu_op", 64'(bus.alu_op), 64'd0);
        chk("rst A", bus.input_alu_A, 64'd0);
        chk("rst B", bus.input_alu_B, 64'd0);
        chk("rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tv[i].in_valid, tv[i].d, tv[i].s);
            chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tv[i].e_vld));
            chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tv[i].e_rdy));
            chk($sformatf("vec%0d stall_cnt", i), 64'(bus.stall_cnt), 64'(tv[i].e_stall));
            if (tv[i].e_vld) begin
                chk($sformatf("vec%0d A", i), bus.input_alu_A, tv[i].e_a);
                chk($sformatf("vec%0d B", i), bus.input_alu_B, tv[i].e_b);
                chk($sformatf("vec%0d store_data", i), bus.out_store_data, tv[i].e_sd);
            end
        end

        // long load-use stall: counter (2 so far) must stop at all-ones
        s_ld5 = sd(1, 5'd5, 1, 1, 64'h0, 5'd0, 0, 64'h0);
        step(1, i4, idle);
        repeat (20) step(0, dz, s_ld5);
        step(0, dz, s_ld5);
        chk("sat stall_cnt", 64'(bus.stall_cnt), 64'hF);
        chk("sat out_valid", 64'(bus.out_valid), 64'd0);
        chk("sat in_ready", 64'(bus.in_ready), 64'd0);
        step(0, dz, idle);
        chk("sat hold", 64'(bus.stall_cnt), 64'hF);
        chk("sat release out_valid", 64'(bus.out_valid), 64'd1);

        // backpressure for 3 cycles, then flush with a live input
        s_stall = idle; s_stall.ex_ready = 1'b0;
        s_flush = idle; s_flush.flush = 1'b1;
        step(0, dz, idle);
        step(1, i1, idle);
        for (int k = 0; k < 3; k++) begin
            step(1, i2, s_stall);
            chk($sformatf("bp%0d out_valid", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d in_ready", k), 64'(bus.in_ready), 64'd0);
            chk($sformatf("bp%0d A", k), bus.input_alu_A, 64'd10);
            chk($sformatf("bp%0d B", k), bus.input_alu_B, 64'd20);
            chk($sformatf("bp%0d alu_op", k), 64'(bus.alu_op), 64'h0);
            chk($sformatf("bp%0d rd_addr", k), 64'(bus.out_rd_addr), 64'd7);
            chk($sformatf("bp%0d rd_we", k), 64'(bus.out_rd_we), 64'd1);
        end
        step(1, i2, s_flush);
        chk("flush in_ready", 64'(bus.in_ready), 64'd1);
        step(0, dz, idle);
        chk("flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush rd_we", 64'(bus.out_rd_we), 64'd0);
        step(0, dz, idle);
        chk("flush dropped", 64'(bus.out_valid), 64'd0);

        // asynchronous reset with an instruction held
        step(1, i5, idle);
        step(0, dz, s_stall);
        chk("pre-arst out_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst A", bus.input_alu_A, 64'd0);
        chk("arst stall_cnt", 64'(bus.stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        m_valid = 1'b0;
        m_q     = '0;
        m_stall = '0;
        for (int c = 0; c < 3000; c++) begin
            logic  v, hz, ev, fire, rdy;
            dec_t  d;
            side_t s;
            v = ($urandom_range(0, 9) < 7);
            d = rnd_dec();
            s = rnd_side();
            step(v, d, s);
            hz   = m_hazard(s);
            ev   = m_valid && !hz;
            fire = ev && s.ex_ready;
            rdy  = !m_valid || fire;
            chk("rnd out_valid", 64'(bus.out_valid), 64'(ev));
            chk("rnd in_ready", 64'(bus.in_ready), 64'(rdy));
            chk("rnd alu_op", 64'(bus.alu_op), 64'(m_q.alu_op));
            chk("rnd A", bus.input_alu_A, m_q.a_sel ? m_q.pc : m_fwd(m_q.rs1_addr, m_q.rs1_data, s));
            chk("rnd B", bus.input_alu_B, m_q.b_sel ? m_q.imm : m_fwd(m_q.rs2_addr, m_q.rs2_data, s));
            chk("rnd store_data", bus.out_store_data, m_fwd(m_q.rs2_addr, m_q.rs2_data, s));
            chk("rnd rd_addr", 64'(bus.out_rd_addr), 64'(m_q.rd_addr));
            chk("rnd rd_we", 64'(bus.out_rd_we), 64'(m_q.rd_we && ev));
            chk("rnd stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
            @(posedge clk);
            if (hz && m_stall != '1) m_stall = m_stall + 1'b1;
            if (s.flush) begin
                m_valid = 1'b0;
            end else if (v && rdy) begin
                m_q     = d;
                m_valid = 1'b1;
            end else begin
                if (m_valid && s.wb_we && s.wb_rd != 5'd0) begin
                    if (s.wb_rd == m_q.rs1_addr) m_q.rs1_data = s.wb_res;
                    if (s.wb_rd == m_q.rs2_addr) m_q.rs2_data = s.wb_res;
                end
                if (fire) m_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
